// File: rtl/dds_phase_reader.sv
// DDS read stage: phase accumulator driving a waveform RAM read port, a valid
// pipeline that tracks the RAM read latency, and a registered amplitude scaler.
module dds_phase_reader #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int AMP_WIDTH   = 16,
  parameter int RAM_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          phase_clr,
  input  logic                          cfg_wr,
  input  logic [PHASE_WIDTH-1:0]        cfg_ftw,
  input  logic [PHASE_WIDTH-1:0]        cfg_pow,
  input  logic                          cfg_deferred,
  input  logic [AMP_WIDTH-1:0]          amp,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic signed [DATA_WIDTH-1:0]  ram_dout,
  output logic                          cfg_pending,
  output logic                          phase_wrap,
  output logic signed [DATA_WIDTH-1:0]  dds_out,
  output logic                          dds_valid
);

  localparam int PROD_W = DATA_WIDTH + AMP_WIDTH + 1;

  function automatic logic signed [DATA_WIDTH-1:0] scale_sample(
    input logic signed [DATA_WIDTH-1:0] s,
    input logic [AMP_WIDTH-1:0]         a
  );
    logic signed [PROD_W-1:0] s_ext;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    s_ext   = $signed({{(AMP_WIDTH+1){s[DATA_WIDTH-1]}}, s});
    a_ext   = $signed({{(DATA_WIDTH+1){1'b0}}, a});
    prod    = s_ext * a_ext;
    shifted = prod >>> AMP_WIDTH;
    return shifted[DATA_WIDTH-1:0];
  endfunction

  logic [PHASE_WIDTH-1:0]        phase_acc_q,  phase_acc_d;
  logic [PHASE_WIDTH-1:0]        ftw_active_q, ftw_active_d;
  logic [PHASE_WIDTH-1:0]        pow_active_q, pow_active_d;
  logic [PHASE_WIDTH-1:0]        ftw_shadow_q, ftw_shadow_d;
  logic [PHASE_WIDTH-1:0]        pow_shadow_q, pow_shadow_d;
  logic                          cfg_pending_q, cfg_pending_d;
  logic                          phase_wrap_q, phase_wrap_d;
  logic [ADDR_WIDTH-1:0]         ram_addr_p0_q, ram_addr_p0_d;
  logic [RAM_LATENCY:0]          vld_q, vld_d;
  logic signed [DATA_WIDTH-1:0]  dds_out_p2_q, dds_out_p2_d;
  logic                          dds_valid_p2_q, dds_valid_p2_d;

  logic [PHASE_WIDTH:0]          acc_sum;
  logic [PHASE_WIDTH-1:0]        addr_phase;
  logic                          wrap_evt;

  assign acc_sum    = {1'b0, phase_acc_q} + {1'b0, ftw_active_q};
  assign addr_phase = phase_acc_q + pow_active_q;
  assign wrap_evt   = en && !phase_clr && acc_sum[PHASE_WIDTH];

  always_comb begin
    phase_acc_d    = phase_acc_q;
    phase_wrap_d   = 1'b0;
    ftw_active_d   = ftw_active_q;
    pow_active_d   = pow_active_q;
    ftw_shadow_d   = ftw_shadow_q;
    pow_shadow_d   = pow_shadow_q;
    cfg_pending_d  = cfg_pending_q;
    ram_addr_p0_d  = ram_addr_p0_q;
    vld_d          = {vld_q[RAM_LATENCY-1:0], en};
    dds_out_p2_d   = dds_out_p2_q;
    dds_valid_p2_d = vld_q[RAM_LATENCY];

    // Stage p0: accumulator and address issue (address uses pre-increment phase)
    if (phase_clr) begin
      phase_acc_d = '0;
    end else if (en) begin
      phase_acc_d  = acc_sum[PHASE_WIDTH-1:0];
      phase_wrap_d = acc_sum[PHASE_WIDTH];
    end
    if (en) begin
      ram_addr_p0_d = addr_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
    end

    // A deferred write landing on the wrap edge applies the previous shadow
    // and re-arms the pending flag for the newly written words.
    if (cfg_wr && !cfg_deferred) begin
      ftw_active_d  = cfg_ftw;
      pow_active_d  = cfg_pow;
      ftw_shadow_d  = cfg_ftw;
      pow_shadow_d  = cfg_pow;
      cfg_pending_d = 1'b0;
    end else begin
      if (wrap_evt && cfg_pending_q) begin
        ftw_active_d  = ftw_shadow_q;
        pow_active_d  = pow_shadow_q;
        cfg_pending_d = 1'b0;
      end
      if (cfg_wr) begin
        ftw_shadow_d  = cfg_ftw;
        pow_shadow_d  = cfg_pow;
        cfg_pending_d = 1'b1;
      end
    end

    // Stage p2: capture the returned sample and scale it
    if (vld_q[RAM_LATENCY]) begin
      dds_out_p2_d = scale_sample(ram_dout, amp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_acc_q    <= '0;
      phase_wrap_q   <= 1'b0;
      ftw_active_q   <= '0;
      pow_active_q   <= '0;
      ftw_shadow_q   <= '0;
      pow_shadow_q   <= '0;
      cfg_pending_q  <= 1'b0;
      ram_addr_p0_q  <= '0;
      vld_q          <= '0;
      dds_out_p2_q   <= '0;
      dds_valid_p2_q <= 1'b0;
    end else begin
      phase_acc_q    <= phase_acc_d;
      phase_wrap_q   <= phase_wrap_d;
      ftw_active_q   <= ftw_active_d;
      pow_active_q   <= pow_active_d;
      ftw_shadow_q   <= ftw_shadow_d;
      pow_shadow_q   <= pow_shadow_d;
      cfg_pending_q  <= cfg_pending_d;
      ram_addr_p0_q  <= ram_addr_p0_d;
      vld_q          <= vld_d;
      dds_out_p2_q   <= dds_out_p2_d;
      dds_valid_p2_q <= dds_valid_p2_d;
    end
  end

  assign ram_we      = 1'b0;
  assign ram_din     = '0;
  assign ram_addr    = ram_addr_p0_q;
  assign cfg_pending = cfg_pending_q;
  assign phase_wrap  = phase_wrap_q;
  assign dds_out     = dds_out_p2_q;
  assign dds_valid   = dds_valid_p2_q;

endmodule

// File: doc/dds_phase_reader.md
# dds_phase_reader

Direct digital synthesis read stage that sits directly downstream of the dual-port waveform RAM. It runs a phase accumulator and drives the RAM's read-only port with the table address. It tracks the RAM's registered read latency with a valid pipeline and captures the returned sample. It then scales the sample by an amplitude word and presents a registered, valid-qualified output.

## Interface
- PHASE_WIDTH, 32, phase accumulator / tuning word width
- ADDR_WIDTH, 10, RAM address width (log2 of table depth)
- DATA_WIDTH, 16, signed two's-complement sample width
- AMP_WIDTH, 16, unsigned amplitude word width
- RAM_LATENCY, 2, clock edges from ram_addr change to valid ram_dout
- clk  in  1  single clock; RAM read port uses the same clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance accumulator and issue one read per cycle
- phase_clr  in  1  synchronous accumulator clear
- cfg_wr  in  1  one-cycle strobe loading cfg_ftw/cfg_pow/cfg_deferred into shadow
- cfg_ftw  in  PHASE_WIDTH  frequency tuning word
- cfg_pow  in  PHASE_WIDTH  phase offset word
- cfg_deferred  in  1  0 = apply next cycle, 1 = apply at next accumulator wrap
- amp  in  AMP_WIDTH  amplitude scale, sampled at the multiply stage
- ram_we  out  1  tied 0
- ram_addr  out  ADDR_WIDTH  registered read address
- ram_din  out  DATA_WIDTH  tied 0
- ram_dout  in  DATA_WIDTH  sample returned by RAM
- cfg_pending  out  1  deferred shadow awaiting wrap
- phase_wrap  out  1  one-cycle pulse on accumulator carry-out
- dds_out  out  DATA_WIDTH  scaled sample
- dds_valid  out  1  dds_out qualifier

## Operation
- Reset sets to 0: phase_acc, ftw_active, pow_active, shadows, cfg_pending, ram_addr, valid pipeline, phase_wrap, dds_out, dds_valid.
- Accumulator: if phase_clr, phase_acc <= 0 and phase_wrap <= 0 (priority over en). Else if en, phase_acc <= phase_acc + ftw_active mod 2^PHASE_WIDTH, and phase_wrap <= carry-out. Else hold, phase_wrap <= 0.
- Address: when en, ram_addr <= top ADDR_WIDTH bits of (phase_acc + pow_active) mod 2^PHASE_WIDTH, computed from the pre-increment accumulator value. No dither, plain truncation. When en = 0, ram_addr holds.
- Config, immediate (cfg_deferred = 0): on cfg_wr, ftw_active/pow_active load at that edge and are first used the following cycle. cfg_pending <= 0.
- Config, deferred: cfg_wr loads the shadow and sets cfg_pending. On an enabled cycle with carry-out while cfg_pending = 1, the active words load from the shadow and cfg_pending clears.
- Simultaneous cfg_wr and wrap in deferred mode: the wrap applies the old shadow contents. The new values are stored and cfg_pending stays 1 until the next wrap.
- phase_clr does not touch the active or shadow configuration.
- Valid pipeline: a RAM_LATENCY+1 deep shift register, input en. It shifts every cycle regardless of en, so in-flight reads drain after en drops.
- Multiply stage: when the pipeline tap at depth RAM_LATENCY is 1, dds_out <= (signed ram_dout × {0, amp}) >>> AMP_WIDTH. The shift is arithmetic (floor), keeping the low DATA_WIDTH bits. Otherwise dds_out holds.
- dds_valid equals the last pipeline bit.

## Timing
- Issue at enabled edge k: ram_addr is valid after k. ram_dout is valid after k+RAM_LATENCY. dds_out/dds_valid update at edge k+RAM_LATENCY+1, which is 3 edges at the default.
- Continuous en gives one sample per cycle, with no bubbles.
- dds_valid is high for exactly as many cycles as en was high, delayed by RAM_LATENCY+1.
- Reset mid-stream clears all valids at once. No stale dds_valid follows reset.
- The config change in immediate mode first affects the address issued on the edge after the edge where cfg_wr is sampled.

## Test plan
- Reset, then load FTW = 0x00400000, POW = 0, amp = 0x8000, RAM[i] = i. Hold en for 8 cycles -> ram_addr is 0,1,…,7. dds_out is 0,0,1,1,2,2,3,3, with dds_valid high 8 cycles starting 3 cycles after en.
- FTW = 0x00400000, acc near the top (run 1023 cycles) -> phase_wrap pulses once as ram_addr wraps 1023→0. With cfg_deferred = 1 FTW = 0x00800000 written earlier, cfg_pending clears at that wrap and the step becomes 2.
- In deferred mode, assert cfg_wr on the same cycle as a wrap -> the old shadow is applied, cfg_pending remains 1, and the new FTW applies at the following wrap.
- POW = 0x80000000 with FTW = 0 -> ram_addr is constant 512. RAM[512] = −100 with amp = 0x8000 gives dds_out = −50. amp = 0 gives dds_out = 0.
- Raise phase_clr together with en mid-run -> the next issued address is POW's top bits and phase_wrap = 0. Assert rst with 3 reads in flight -> dds_valid stays 0 afterwards and all outputs read 0.
